// File: rtl/mem_read_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_read_stage
// Purpose  : Pop-side reader for a 1-cycle-latency SRAM queue, with a
//            credit-controlled read-ahead into a 2-entry head/skid stage.
// Revision : 1.0
// ============================================================================
module mem_read_stage #(
   parameter int W = 32,
   parameter int N = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [$clog2(N):0]   wptr,
   output logic [$clog2(N):0]   rptr_r,
   output logic                 mem_ren,
   output logic [$clog2(N)-1:0] mem_raddr,
   input  logic [W-1:0]         mem_rdata,
   input  logic                 out_accept,
   output logic                 out_valid_r,
   output logic [W-1:0]         out_data_r,
   output logic                 empty_r
);

   localparam int PTR_BITS = $clog2(N) + 1;

   logic [PTR_BITS-1:0] rptr_q, rptr_d;
   logic                head_vld_q, head_vld_d;
   logic [W-1:0]        head_data_q, head_data_d;
   logic                skid_vld_q, skid_vld_d;
   logic [W-1:0]        skid_data_q, skid_data_d;
   logic                inflight_q;

   logic [PTR_BITS-1:0] avail;
   logic                pop;
   logic [1:0]          credit_used;
   logic                ren;

   assign avail       = wptr - rptr_q;
   assign pop         = head_vld_q & out_accept;
   assign credit_used = {1'b0, head_vld_q} + {1'b0, skid_vld_q} + {1'b0, inflight_q};

   // Issue only while the entries held plus the one in flight, less any pop,
   // leave a free slot; this is what keeps the skid from overflowing.
   assign ren = ~rst & (avail != '0) & ({1'b0, credit_used} < (3'd2 + {2'b00, pop}));

   always_comb begin
      rptr_d      = rptr_q + {{(PTR_BITS-1){1'b0}}, ren};
      head_vld_d  = head_vld_q;
      head_data_d = head_data_q;
      skid_vld_d  = skid_vld_q;
      skid_data_d = skid_data_q;
      if (inflight_q) begin
         if (!head_vld_q || pop) begin
            head_vld_d = 1'b1;
            if (skid_vld_q) begin
               head_data_d = skid_data_q;
               skid_data_d = mem_rdata;
            end else begin
               head_data_d = mem_rdata;
            end
         end else begin
            skid_vld_d  = 1'b1;
            skid_data_d = mem_rdata;
         end
      end else if (pop) begin
         if (skid_vld_q) begin
            head_data_d = skid_data_q;
            skid_vld_d  = 1'b0;
         end else begin
            head_vld_d  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rptr_q      <= '0;
         head_vld_q  <= 1'b0;
         head_data_q <= '0;
         skid_vld_q  <= 1'b0;
         skid_data_q <= '0;
         inflight_q  <= 1'b0;
      end else begin
         rptr_q      <= rptr_d;
         head_vld_q  <= head_vld_d;
         head_data_q <= head_data_d;
         skid_vld_q  <= skid_vld_d;
         skid_data_q <= skid_data_d;
         inflight_q  <= ren;
      end
   end

   assign rptr_r      = rptr_q;
   assign mem_ren     = ren;
   assign mem_raddr   = rptr_q[PTR_BITS-2:0];
   assign out_valid_r = head_vld_q;
   assign out_data_r  = head_data_q;
   assign empty_r     = ~head_vld_q;

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (avail <= PTR_BITS'(N))
            else $error("mem_read_stage: wptr is more than N entries ahead of rptr");
         assert (!(inflight_q && head_vld_q && !pop && skid_vld_q))
            else $error("mem_read_stage: return arrived with head held and skid full");
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_read_stage.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for mem_read_stage: directed vector table, directed multi-cycle
// sequences and a randomized run checked against a queue-level model.
module tb_mem_read_stage;
   localparam int W   = 32;
   localparam int N   = 16;
   localparam int PB  = $clog2(N) + 1;
   localparam int MOD = 1 << PB;

   logic          clk = 1'b0;
   logic          rst;
   logic [PB-1:0] wptr;
   logic [PB-1:0] rptr_r;
   logic          mem_ren;
   logic [PB-2:0] mem_raddr;
   logic [W-1:0]  mem_rdata;
   logic          out_accept;
   logic          out_valid_r;
   logic [W-1:0]  out_data_r;
   logic          empty_r;

   always #5 clk = ~clk;

   mem_read_stage #(.W(W), .N(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .wptr       (wptr),
      .rptr_r     (rptr_r),
      .mem_ren    (mem_ren),
      .mem_raddr  (mem_raddr),
      .mem_rdata  (mem_rdata),
      .out_accept (out_accept),
      .out_valid_r(out_valid_r),
      .out_data_r (out_data_r),
      .empty_r    (empty_r)
   );

   logic [W-1:0] sram [N];
   int vectors     = 0;
   int miscompares = 0;

   // Reference model: read count, queue of delivered-but-unconsumed data,
   // and the one SRAM return that is on its way.
   int           m_rptr;
   logic [W-1:0] m_stage [$];
   bit           m_pend;
   logic [W-1:0] m_pdata;
   logic [PB-1:0] wp;

   int addr_log [$];
   int pops, first_pop, last_pop, cyc;

   typedef struct {
      bit            r;
      logic [PB-1:0] wp;
      bit            acc;
      bit            ren;
      logic [PB-2:0] raddr;
      bit            valid;
      logic [W-1:0]  data;
      logic [PB-1:0] rptr;
   } vec_t;
   vec_t tbl [24];

   function automatic vec_t V(bit r, int w, bit acc, bit ren, int ra, bit v,
                              logic [W-1:0] d, int rp);
      vec_t x;
      x.r = r; x.wp = PB'(w); x.acc = acc; x.ren = ren; x.raddr = (PB-1)'(ra);
      x.valid = v; x.data = d; x.rptr = PB'(rp);
      return x;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // SRAM: one-cycle read latency; garbage on the bus when no read was issued.
   task automatic advance();
      logic          s_ren;
      logic [PB-2:0] s_addr;
      s_ren  = mem_ren;
      s_addr = mem_raddr;
      @(posedge clk);
      #1;
      mem_rdata = s_ren ? sram[s_addr] : $urandom();
   endtask

   task automatic mcycle(input bit r, input logic [PB-1:0] w, input bit acc);
      int           avail;
      bit           pop, ren;
      logic [W-1:0] rd;
      rst = r; wptr = w; out_accept = acc;
      @(negedge clk);
      avail = (int'(w) - m_rptr) & (MOD - 1);
      pop   = (m_stage.size() != 0) && acc;
      ren   = !r && (avail != 0) && ((m_stage.size() + int'(m_pend) - int'(pop)) < 2);
      check("ren", 64'(mem_ren), 64'(ren));
      if (ren) check("raddr", 64'(mem_raddr), 64'(m_rptr % N));
      check("rptr", 64'(rptr_r), 64'(m_rptr));
      check("valid", 64'(out_valid_r), 64'(m_stage.size() != 0));
      check("empty", 64'(empty_r), 64'(m_stage.size() == 0));
      if (m_stage.size() != 0) check("data", 64'(out_data_r), 64'(m_stage[0]));
      if (mem_ren) addr_log.push_back(int'(mem_raddr));
      if (out_valid_r && acc) begin
         if (pops == 0) first_pop = cyc;
         last_pop = cyc;
         pops++;
      end
      cyc++;
      rd = sram[m_rptr % N];
      if (r) begin
         m_stage.delete();
         m_pend = 1'b0;
         m_rptr = 0;
      end else begin
         if (pop) void'(m_stage.pop_front());
         if (m_pend) m_stage.push_back(m_pdata);
         m_pend  = ren;
         m_pdata = rd;
         if (ren) m_rptr = (m_rptr + 1) % MOD;
      end
      advance();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; wptr = '0; out_accept = 1'b0; mem_rdata = '0;
      for (int i = 0; i < N; i++) sram[i] = 32'h1000_0000 + i;
      sram[0] = 32'hA5A5_0001;
      repeat (2) @(posedge clk);
      #1;

      // reset/idle, single entry, then backpressure and release
      tbl[0]  = V(1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 1; i <= 5; i++) tbl[i] = V(0, 0, 1, 0, 0, 0, 0, 0);
      tbl[6]  = V(0, 1, 1, 1, 0, 0, 0, 0);
      tbl[7]  = V(0, 1, 1, 0, 0, 0, 0, 1);
      tbl[8]  = V(0, 1, 1, 0, 0, 1, 32'hA5A5_0001, 1);
      tbl[9]  = V(0, 1, 1, 0, 0, 0, 0, 1);
      tbl[10] = V(0, 9, 0, 1, 1, 0, 0, 1);
      tbl[11] = V(0, 9, 0, 1, 2, 0, 0, 2);
      tbl[12] = V(0, 9, 0, 0, 0, 1, 32'h1000_0001, 3);
      tbl[13] = V(0, 9, 0, 0, 0, 1, 32'h1000_0001, 3);
      tbl[14] = V(0, 9, 0, 0, 0, 1, 32'h1000_0001, 3);
      tbl[15] = V(0, 9, 1, 1, 3, 1, 32'h1000_0001, 3);
      tbl[16] = V(0, 9, 1, 1, 4, 1, 32'h1000_0002, 4);
      tbl[17] = V(0, 9, 1, 1, 5, 1, 32'h1000_0003, 5);
      tbl[18] = V(0, 9, 1, 1, 6, 1, 32'h1000_0004, 6);
      tbl[19] = V(0, 9, 1, 1, 7, 1, 32'h1000_0005, 7);
      tbl[20] = V(0, 9, 1, 1, 8, 1, 32'h1000_0006, 8);
      tbl[21] = V(0, 9, 1, 0, 0, 1, 32'h1000_0007, 9);
      tbl[22] = V(0, 9, 1, 0, 0, 1, 32'h1000_0008, 9);
      tbl[23] = V(0, 9, 1, 0, 0, 0, 0, 9);

      for (int i = 0; i < 24; i++) begin
         rst = tbl[i].r; wptr = tbl[i].wp; out_accept = tbl[i].acc;
         @(negedge clk);
         check($sformatf("tbl%0d_ren", i), 64'(mem_ren), 64'(tbl[i].ren));
         if (tbl[i].ren) check($sformatf("tbl%0d_raddr", i), 64'(mem_raddr), 64'(tbl[i].raddr));
         check($sformatf("tbl%0d_valid", i), 64'(out_valid_r), 64'(tbl[i].valid));
         check($sformatf("tbl%0d_empty", i), 64'(empty_r), 64'(!tbl[i].valid));
         if (tbl[i].valid) check($sformatf("tbl%0d_data", i), 64'(out_data_r), 64'(tbl[i].data));
         check($sformatf("tbl%0d_rptr", i), 64'(rptr_r), 64'(tbl[i].rptr));
         advance();
      end

      // Model-checked phase starts from a clean reset
      rst = 1'b1; wptr = '0; out_accept = 1'b0;
      @(posedge clk);
      #1;
      m_rptr = 0; m_stage.delete(); m_pend = 1'b0; wp = '0;

      // Streaming: full queue drained at one pop per cycle
      for (int i = 0; i < N; i++) sram[i] = i;
      wp = PB'(16);
      pops = 0; cyc = 0;
      repeat (22) mcycle(1'b0, wp, 1'b1);
      check("stream_pops", 64'(pops), 64'(16));
      check("stream_nobubble", 64'(last_pop - first_pop), 64'(15));
      check("stream_rptr", 64'(rptr_r), 64'(16));

      // Walk pointers to 30, then push 4 across the wrap
      repeat (14) begin
         sram[int'(wp) % N] = $urandom();
         wp = wp + 1'b1;
         mcycle(1'b0, wp, 1'b1);
      end
      repeat (4) mcycle(1'b0, wp, 1'b1);
      check("wrap_pre_rptr", 64'(rptr_r), 64'(30));
      addr_log.delete();
      for (int k = 0; k < 4; k++) sram[(int'(wp) + k) % N] = $urandom();
      wp = wp + PB'(4);
      repeat (8) mcycle(1'b0, wp, 1'b1);
      check("wrap_nren", 64'(addr_log.size()), 64'(4));
      if (addr_log.size() == 4) begin
         check("wrap_addr0", 64'(addr_log[0]), 64'(14));
         check("wrap_addr1", 64'(addr_log[1]), 64'(15));
         check("wrap_addr2", 64'(addr_log[2]), 64'(0));
         check("wrap_addr3", 64'(addr_log[3]), 64'(1));
      end
      check("wrap_rptr", 64'(rptr_r), 64'(2));
      check("wrap_avail", 64'(wp - rptr_r), 64'(0));

      // Reset with a head entry held and a read in flight
      for (int k = 0; k < 4; k++) sram[(int'(wp) + k) % N] = $urandom();
      wp = wp + PB'(4);
      mcycle(1'b0, wp, 1'b0);
      mcycle(1'b0, wp, 1'b0);
      check("pre_rst_valid", 64'(out_valid_r), 64'(1));
      wp = '0;
      mcycle(1'b1, wp, 1'b0);
      mcycle(1'b0, wp, 1'b1);
      check("post_rst_valid", 64'(out_valid_r), 64'(0));
      check("post_rst_rptr", 64'(rptr_r), 64'(0));
      repeat (3) mcycle(1'b0, wp, 1'b1);
      check("post_rst_stale", 64'(out_valid_r), 64'(0));

      // Randomized traffic with varying backpressure and occasional reset
      for (int c = 0; c < 3000; c++) begin
         bit r, acc;
         int lvl;
         lvl = (c / 250) % 3;
         r   = ($urandom_range(0, 399) == 0);
         case (lvl)
            0:       acc = ($urandom_range(0, 9) == 0);
            1:       acc = ($urandom_range(0, 1) == 1);
            default: acc = ($urandom_range(0, 9) != 0);
         endcase
         if (r) begin
            wp = '0;
         end else if (($urandom_range(0, 9) < 7) && (((int'(wp) - m_rptr) & (MOD - 1)) < N)) begin
            sram[int'(wp) % N] = $urandom();
            wp = wp + 1'b1;
         end
         mcycle(r, wp, acc);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_read_stage.md
Name: mem_read_stage

Overview:
- Single-clock pop-side reader for a 1-cycle-latency SRAM-backed queue. It is the read end that pairs with the producer-side write pointer.
- Compares the producer's binary write pointer against its own read pointer and issues SRAM reads ahead of demand.
- Buffers returned data in a 2-entry output/skid stage and presents it on a valid/accept interface at full throughput.
- Exports its read pointer so the producer can compute full.

Parameters:
- W, 32, data width in bits.
- N, 16, queue depth in entries; power of two, at least 2.
- PTR_BITS, $clog2(N)+1, pointer width (derived; not overridable).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- wptr  in  PTR_BITS  producer write pointer, binary, same clock domain, wraps modulo 2^PTR_BITS.
- rptr_r  out  PTR_BITS  read pointer, registered; count of reads issued, modulo 2^PTR_BITS.
- mem_ren  out  1  SRAM read enable.
- mem_raddr  out  PTR_BITS-1  SRAM read address, equal to rptr_r[PTR_BITS-2:0].
- mem_rdata  in  W  SRAM read data, valid the cycle after mem_ren.
- out_accept  in  1  consumer takes the head entry this cycle when out_valid_r=1.
- out_valid_r  out  1  head entry valid, registered.
- out_data_r  out  W  head entry data, registered.
- empty_r  out  1  equals ~out_valid_r.

Behaviour:
- Reset values: rptr_r=0, out_valid_r=0, out_data_r=0, skid valid=0, inflight=0, empty_r=1. mem_ren=0 in any cycle where rst=1.
- avail = (wptr - rptr_r) mod 2^PTR_BITS; legal range 0..N. A value above N is a protocol violation; flag it with a simulation assertion.
- pop = out_valid_r & out_accept.
- occ = out_valid_r + skid_valid, range 0..2. inflight_r (1 bit) is set when mem_ren fired in the previous cycle.
- Issue rule: mem_ren = ~rst & (avail != 0) & ((occ + inflight_r - pop) < 2). All terms are combinational from registered state plus wptr and out_accept.
- On mem_ren, rptr_r advances by 1 at the clock edge and wraps naturally. mem_raddr = rptr_r low bits before the increment.
- Return capture, when inflight_r=1, at the end of the return cycle:
  - If the head is empty or popping and the skid is empty, mem_rdata loads the head.
  - If the head is empty or popping and the skid is full, the skid moves to the head and mem_rdata loads the skid.
  - If the head is held (valid, not accepted), mem_rdata loads the skid.
- Without a return, a pop refills the head from the skid if the skid is valid; otherwise out_valid_r clears.
- Ordering is strict FIFO: out_data_r is always the oldest unconsumed entry.
- Latency: wptr rises from equal to rptr_r+1 in cycle t with an empty stage → mem_ren in cycle t, mem_rdata in t+1, out_valid_r=1 in t+2.
- Throughput: with out_accept held high and avail>0, one mem_ren and one pop per cycle sustained.
- Backpressure: with out_accept=0, at most 2 entries are read ahead; mem_ren stays low afterwards even if avail>0. The skid never overflows, guaranteed by the credit rule.
- Simultaneous pop and return: handled in the same cycle with no bubble and no loss.
- Pointer wrap: rptr_r passes 2^PTR_BITS-1 → 0 with correct avail arithmetic and the address wrapping at N.
- Reset mid-operation: rst clears all state in one cycle. A return arriving the cycle after rst deasserts is dropped, because inflight_r=0. The producer must also reset wptr to 0.
- out_data_r holds its value while out_valid_r=1 and out_accept=0. Data is don't-care when invalid.

Test Plan:
- Reset then idle (wptr=0, 10 cycles) → mem_ren=0 throughout, out_valid_r=0, empty_r=1, rptr_r=0.
- Single entry: SRAM[0]=0xA5A5_0001, wptr 0→1 at cycle t, out_accept=1 → mem_ren at t with mem_raddr=0, out_valid_r=1 at t+2 with data 0xA5A5_0001, empty_r=1 at t+3, rptr_r=1.
- Streaming: wptr=16, SRAM[i]=i, out_accept=1 → 16 consecutive pops with data 0..15, no bubbles after the first, rptr_r=16.
- Backpressure: wptr=8, out_accept=0 for 20 cycles → exactly 2 mem_ren pulses, rptr_r=2, head=0. Then out_accept=1 → data 0..7 in order with no drops.
- Wrap: preset rptr_r and wptr to 30 via 30 push/pop cycles, then wptr=34 (mod 32 → 2) → 4 pops with addresses 14,15,0,1; final rptr_r=2; avail=0.
- Reset mid-stream: assert rst for 1 cycle while a read is in flight and the skid is full → next cycle out_valid_r=0, rptr_r=0, and the stale return is not presented.
